// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI read/write master.
// Holds the read/write FSM state enums, fixed bus widths and the AXI
// size/burst encodings used on both address channels.
package axi_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ID_W   = 4;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
// Ports: i_req   - request bits (0 = icache, 1 = dcache)
//        i_last  - index of the requester granted last
//        o_gnt   - one-hot grant, all zero when nothing requests
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// AXI master shared by an icache and a dcache. Reads from either cache are
// arbitrated round-robin; the dcache alone issues writes. Read and write
// paths are independent and each carries one outstanding transaction.
// Ports: clk/rst           - core clock, synchronous active-high reset
//        rreq_* / rresp_*  - per-requester read request and beat return
//        wreq_* / wdata_*  - dcache write request and beat handshake
//        wdone_o           - write completion pulse (B accepted)
//        ar_*, r_*         - AXI read address / read data channels
//        aw_*, w_*, b_*    - AXI write address / data / response channels
module axi_master_arbiter
  import axi_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rreq_valid_i,
  output logic [1:0]       rreq_ready_o,
  input  logic [1:0][31:0] rreq_addr_i,
  input  logic [1:0][7:0]  rreq_len_i,
  output logic [1:0]       rresp_valid_o,
  output logic [31:0]      rresp_data_o,
  output logic             rresp_last_o,
  input  logic             wreq_valid_i,
  output logic             wreq_ready_o,
  input  logic [31:0]      wreq_addr_i,
  input  logic [7:0]       wreq_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  output logic             wdone_o,
  output logic [3:0]       ar_id,
  output logic [31:0]      ar_addr,
  output logic [7:0]       ar_len,
  output logic [2:0]       ar_size,
  output logic [1:0]       ar_burst,
  output logic [1:0]       ar_lock,
  output logic [3:0]       ar_cache,
  output logic [2:0]       ar_prot,
  output logic             ar_valid,
  input  logic             ar_ready,
  input  logic [3:0]       r_id,
  input  logic [31:0]      r_data,
  input  logic [1:0]       r_resp,
  input  logic             r_last,
  input  logic             r_valid,
  output logic             r_ready,
  output logic [3:0]       aw_id,
  output logic [31:0]      aw_addr,
  output logic [7:0]       aw_len,
  output logic [2:0]       aw_size,
  output logic [1:0]       aw_burst,
  output logic [1:0]       aw_lock,
  output logic [3:0]       aw_cache,
  output logic [2:0]       aw_prot,
  output logic             aw_valid,
  input  logic             aw_ready,
  output logic [31:0]      w_data,
  output logic [3:0]       w_strb,
  output logic             w_last,
  output logic             w_valid,
  input  logic             w_ready,
  input  logic [3:0]       b_id,
  input  logic [1:0]       b_resp,
  input  logic             b_valid,
  output logic             b_ready
);

  rd_state_e         r_rstate;
  logic              r_last_gnt;
  logic              r_gnt;
  logic [ADDR_W-1:0] r_raddr;
  logic [LEN_W-1:0]  r_rlen;

  wr_state_e         r_wstate;
  logic [ADDR_W-1:0] r_waddr;
  logic [LEN_W-1:0]  r_wlen;
  logic [LEN_W-1:0]  r_beat;

  logic [1:0] w_gnt;
  logic       w_rd_idle;
  logic       w_rd_data;
  logic       w_wr_data;
  logic       w_whs;
  logic       w_wlast;
  logic       w_unused;

  rr_arbiter2 u_rr (
    .i_req  (rreq_valid_i),
    .i_last (r_last_gnt),
    .o_gnt  (w_gnt)
  );

  // Read path: grant, address phase, then beats until r_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate   <= R_IDLE;
      r_last_gnt <= 1'b1;
      r_gnt      <= 1'b0;
      r_raddr    <= '0;
      r_rlen     <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (|w_gnt) begin
            r_gnt    <= w_gnt[1];
            r_raddr  <= rreq_addr_i[w_gnt[1]];
            r_rlen   <= rreq_len_i[w_gnt[1]];
            r_rstate <= R_AR;
          end
        end
        R_AR: begin
          if (ar_ready) r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (r_valid && r_last) begin
            r_last_gnt <= r_gnt;
            r_rstate   <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Write path: accept, address phase, counted beats, B response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_beat   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (wreq_valid_i) begin
            r_waddr  <= wreq_addr_i;
            r_wlen   <= wreq_len_i;
            r_beat   <= '0;
            r_wstate <= W_AW;
          end
        end
        W_AW: begin
          if (aw_ready) r_wstate <= W_DATA;
        end
        W_DATA: begin
          if (w_whs) begin
            r_beat <= r_beat + LEN_W'(1);
            if (w_wlast) r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_valid) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign w_rd_idle = (r_rstate == R_IDLE);
  assign w_rd_data = (r_rstate == R_DATA);
  assign w_wr_data = (r_wstate == W_DATA);
  assign w_whs     = w_wr_data && wdata_valid_i && w_ready;
  assign w_wlast   = w_wr_data && (r_beat == r_wlen);

  // Accept pulses are suppressed while reset is held so nothing is granted.
  assign rreq_ready_o  = (w_rd_idle && !rst) ? w_gnt : 2'b00;
  assign rresp_valid_o = (w_rd_data && r_valid) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign rresp_data_o  = r_data;
  assign rresp_last_o  = w_rd_data && r_last;
  assign r_ready       = w_rd_data;

  assign ar_valid = (r_rstate == R_AR);
  assign ar_id    = ID_W'(r_gnt);
  assign ar_addr  = r_raddr;
  assign ar_len   = r_rlen;
  assign ar_size  = AXI_SIZE_4B;
  assign ar_burst = AXI_BURST_INCR;
  assign ar_lock  = 2'b00;
  assign ar_cache = 4'b0000;
  assign ar_prot  = 3'b000;

  assign wreq_ready_o  = (r_wstate == W_IDLE) && wreq_valid_i && !rst;
  assign aw_valid      = (r_wstate == W_AW);
  assign aw_id         = ID_W'(1);
  assign aw_addr       = r_waddr;
  assign aw_len        = r_wlen;
  assign aw_size       = AXI_SIZE_4B;
  assign aw_burst      = AXI_BURST_INCR;
  assign aw_lock       = 2'b00;
  assign aw_cache      = 4'b0000;
  assign aw_prot       = 3'b000;

  assign w_valid       = w_wr_data && wdata_valid_i;
  assign wdata_ready_o = w_wr_data && w_ready;
  assign w_data        = wdata_i;
  assign w_strb        = wstrb_i;
  assign w_last        = w_wlast;
  assign b_ready       = (r_wstate == W_RESP);
  assign wdone_o       = (r_wstate == W_RESP) && b_valid;

  // Response codes and IDs carry no information for this master.
  assign w_unused = ^{r_id, r_resp, b_id, b_resp};

endmodule

// File: tb/tb_axi_master_arbiter.sv
module tb_axi_master_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       rreq_valid_i;
  logic [1:0]       rreq_ready_o;
  logic [1:0][31:0] rreq_addr_i;
  logic [1:0][7:0]  rreq_len_i;
  logic [1:0]       rresp_valid_o;
  logic [31:0]      rresp_data_o;
  logic             rresp_last_o;
  logic             wreq_valid_i, wreq_ready_o;
  logic [31:0]      wreq_addr_i;
  logic [7:0]       wreq_len_i;
  logic             wdata_valid_i, wdata_ready_o;
  logic [31:0]      wdata_i;
  logic [3:0]       wstrb_i;
  logic             wdone_o;
  logic [3:0]       ar_id, aw_id, r_id, b_id;
  logic [31:0]      ar_addr, aw_addr, r_data, w_data;
  logic [7:0]       ar_len, aw_len;
  logic [2:0]       ar_size, aw_size, ar_prot, aw_prot;
  logic [1:0]       ar_burst, aw_burst, ar_lock, aw_lock, r_resp, b_resp;
  logic [3:0]       ar_cache, aw_cache, w_strb;
  logic             ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic             aw_valid, aw_ready, w_last, w_valid, w_ready;
  logic             b_valid, b_ready;

  axi_master_arbiter dut (
    .clk(clk), .rst(rst),
    .rreq_valid_i(rreq_valid_i), .rreq_ready_o(rreq_ready_o),
    .rreq_addr_i(rreq_addr_i), .rreq_len_i(rreq_len_i),
    .rresp_valid_o(rresp_valid_o), .rresp_data_o(rresp_data_o), .rresp_last_o(rresp_last_o),
    .wreq_valid_i(wreq_valid_i), .wreq_ready_o(wreq_ready_o),
    .wreq_addr_i(wreq_addr_i), .wreq_len_i(wreq_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wdone_o(wdone_o),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
    .r_ready(r_ready),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the read bus and which phase of
  // each transaction is still outstanding.
  int          m_rd_owner = -1;
  bit          m_rd_apend = 1'b0;
  int          m_prev     = 1;
  logic [31:0] m_rd_addr  = '0;
  logic [7:0]  m_rd_len   = '0;
  bit          m_wr_act   = 1'b0;
  bit          m_wr_apend = 1'b0;
  bit          m_wr_b     = 1'b0;
  int          m_wr_beats = 0;
  logic [31:0] m_wr_addr  = '0;
  logic [7:0]  m_wr_len   = '0;

  function automatic logic [1:0] pick(input logic [1:0] v, input int prev);
    if (v == 2'b11) return (prev == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_rd_owner = -1; m_rd_apend = 1'b0; m_prev = 1;
      m_wr_act = 1'b0; m_wr_apend = 1'b0; m_wr_b = 1'b0; m_wr_beats = 0;
    end else begin
      if (m_rd_owner < 0) begin
        if (rreq_valid_i != 2'b00) begin
          m_rd_owner = (pick(rreq_valid_i, m_prev) == 2'b10) ? 1 : 0;
          m_rd_apend = 1'b1;
          m_rd_addr  = rreq_addr_i[m_rd_owner];
          m_rd_len   = rreq_len_i[m_rd_owner];
        end
      end else if (m_rd_apend) begin
        if (ar_ready) m_rd_apend = 1'b0;
      end else if (r_valid && r_last) begin
        m_prev     = m_rd_owner;
        m_rd_owner = -1;
      end
      if (!m_wr_act) begin
        if (wreq_valid_i) begin
          m_wr_act = 1'b1; m_wr_apend = 1'b1; m_wr_b = 1'b0; m_wr_beats = 0;
          m_wr_addr = wreq_addr_i; m_wr_len = wreq_len_i;
        end
      end else if (m_wr_apend) begin
        if (aw_ready) m_wr_apend = 1'b0;
      end else if (!m_wr_b) begin
        if (wdata_valid_i && w_ready) begin
          if (m_wr_beats == int'(m_wr_len)) m_wr_b = 1'b1;
          else m_wr_beats++;
        end
      end else if (b_valid) begin
        m_wr_act = 1'b0; m_wr_b = 1'b0;
      end
    end
  end

  logic [1:0] e_pick, e_rv;
  bit e_arv, e_rrdy, e_awv, e_wd;
  int wdone_cnt = 0, rv0_cnt = 0, rv1_cnt = 0, wlast_cnt = 0;

  // Per-cycle comparison against the reference, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      e_pick = (m_rd_owner < 0 && !rst) ? pick(rreq_valid_i, m_prev) : 2'b00;
      chk("rreq_ready", 64'(rreq_ready_o), 64'(e_pick));
      e_arv = (m_rd_owner >= 0) && m_rd_apend;
      chk("ar_valid", 64'(ar_valid), 64'(e_arv));
      if (e_arv) begin
        chk("ar_addr", 64'(ar_addr), 64'(m_rd_addr));
        chk("ar_len", 64'(ar_len), 64'(m_rd_len));
        chk("ar_id", 64'(ar_id), 64'(m_rd_owner));
      end
      e_rrdy = (m_rd_owner >= 0) && !m_rd_apend;
      chk("r_ready", 64'(r_ready), 64'(e_rrdy));
      e_rv = 2'b00;
      if (e_rrdy && r_valid) e_rv = (m_rd_owner == 1) ? 2'b10 : 2'b01;
      chk("rresp_valid", 64'(rresp_valid_o), 64'(e_rv));
      chk("rresp_last", 64'(rresp_last_o), 64'(e_rrdy && r_last));
      chk("rresp_data", 64'(rresp_data_o), 64'(r_data));
      chk("ar_const", 64'({ar_size, ar_burst, ar_lock, ar_cache, ar_prot}),
          64'({3'b010, 2'b01, 2'b00, 4'b0000, 3'b000}));
      chk("aw_const", 64'({aw_id, aw_size, aw_burst, aw_lock, aw_cache, aw_prot}),
          64'({4'd1, 3'b010, 2'b01, 2'b00, 4'b0000, 3'b000}));
      chk("wreq_ready", 64'(wreq_ready_o), 64'(!m_wr_act && wreq_valid_i && !rst));
      e_awv = m_wr_act && m_wr_apend;
      chk("aw_valid", 64'(aw_valid), 64'(e_awv));
      if (e_awv) begin
        chk("aw_addr", 64'(aw_addr), 64'(m_wr_addr));
        chk("aw_len", 64'(aw_len), 64'(m_wr_len));
      end
      e_wd = m_wr_act && !m_wr_apend && !m_wr_b;
      chk("w_valid", 64'(w_valid), 64'(e_wd && wdata_valid_i));
      chk("wdata_ready", 64'(wdata_ready_o), 64'(e_wd && w_ready));
      chk("w_last", 64'(w_last), 64'(e_wd && (m_wr_beats == int'(m_wr_len))));
      chk("w_payload", 64'({w_strb, w_data}), 64'({wstrb_i, wdata_i}));
      chk("b_ready", 64'(b_ready), 64'(m_wr_b));
      chk("wdone", 64'(wdone_o), 64'(m_wr_b && b_valid));
      if (wdone_o) wdone_cnt++;
      if (rresp_valid_o[0]) rv0_cnt++;
      if (rresp_valid_o[1]) rv1_cnt++;
      if (w_last && w_valid && wdata_ready_o) wlast_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int c0, c1, cw, cl, last_idx;

  initial begin
    rst = 1'b1;
    rreq_valid_i = '0; rreq_addr_i = '0; rreq_len_i = '0;
    wreq_valid_i = 1'b0; wreq_addr_i = '0; wreq_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0; wstrb_i = '0;
    ar_ready = 1'b0; r_id = 4'hF; r_data = '0; r_resp = 2'b10; r_last = 1'b0; r_valid = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_id = 4'hF; b_resp = 2'b11; b_valid = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_r_ready", 64'(r_ready), 64'd0);
    chk("rst_aw_valid", 64'(aw_valid), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    tick();
    rst = 1'b0;

    // Icache burst read, 4 beats, ar_ready after two address cycles.
    rreq_valid_i = 2'b01; rreq_addr_i[0] = 32'h1C00_0000; rreq_len_i[0] = 8'd3;
    @(negedge clk);
    chk("t1_grant", 64'(rreq_ready_o), 64'b01);
    tick();
    rreq_valid_i = 2'b00;
    @(negedge clk);
    chk("t1_ar_id", 64'(ar_id), 64'd0);
    chk("t1_ar_len", 64'(ar_len), 64'd3);
    chk("t1_ar_addr", 64'(ar_addr), 64'h1C00_0000);
    tick();
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    c0 = rv0_cnt; c1 = rv1_cnt; last_idx = -1;
    for (int b = 0; b < 4; b++) begin
      r_valid = 1'b1; r_data = 32'hA000_0000 + 32'(b); r_last = (b == 3);
      @(negedge clk);
      if (rresp_last_o) last_idx = b;
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0;
    @(negedge clk);
    chk("t1_beats0", 64'(rv0_cnt - c0), 64'd4);
    chk("t1_beats1", 64'(rv1_cnt - c1), 64'd0);
    chk("t1_last_beat", 64'(last_idx), 64'd3);
    chk("t1_idle_r_ready", 64'(r_ready), 64'd0);

    // Simultaneous reads after reset: icache first, dcache right after r_last.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rreq_valid_i = 2'b11;
    rreq_addr_i[0] = 32'h0000_0100; rreq_len_i[0] = 8'd0;
    rreq_addr_i[1] = 32'h0000_0200; rreq_len_i[1] = 8'd0;
    @(negedge clk);
    chk("t2_first", 64'(rreq_ready_o), 64'b01);
    tick();
    rreq_valid_i = 2'b10; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0; r_valid = 1'b1; r_last = 1'b1; r_data = 32'h1111_0000;
    @(negedge clk);
    chk("t2_beat0", 64'(rresp_valid_o), 64'b01);
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    @(negedge clk);
    chk("t2_second", 64'(rreq_ready_o), 64'b10);
    tick();
    rreq_valid_i = 2'b00;
    @(negedge clk);
    chk("t2_ar_id1", 64'(ar_id), 64'd1);
    chk("t2_ar_addr1", 64'(ar_addr), 64'h0000_0200);
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0; r_valid = 1'b1; r_last = 1'b1; r_data = 32'h2222_0000;
    @(negedge clk);
    chk("t2_beat1", 64'(rresp_valid_o), 64'b10);
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    // After serving requester 1, a tie goes back to requester 0.
    rreq_valid_i = 2'b11;
    @(negedge clk);
    chk("t2_tie", 64'(rreq_ready_o), 64'b01);
    tick();
    rreq_valid_i = 2'b00; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0; r_valid = 1'b1; r_last = 1'b1;
    tick();
    r_valid = 1'b0; r_last = 1'b0;

    // Dcache write, 2 beats, w_ready stalled for 3 cycles.
    cw = wdone_cnt; cl = wlast_cnt;
    wreq_valid_i = 1'b1; wreq_addr_i = 32'h8000_0040; wreq_len_i = 8'd1;
    @(negedge clk);
    chk("t3_accept", 64'(wreq_ready_o), 64'd1);
    tick();
    wreq_valid_i = 1'b0;
    @(negedge clk);
    chk("t3_aw_addr", 64'(aw_addr), 64'h8000_0040);
    chk("t3_aw_len", 64'(aw_len), 64'd1);
    aw_ready = 1'b1;
    tick();
    aw_ready = 1'b0; wdata_valid_i = 1'b1; wdata_i = 32'hDEAD_0001; wstrb_i = 4'hF;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t3_stall_last", 64'(w_last), 64'd0);
      tick();
    end
    w_ready = 1'b1;
    @(negedge clk);
    chk("t3_beat1_last", 64'(w_last), 64'd0);
    tick();
    wdata_i = 32'hDEAD_0002; wstrb_i = 4'h3;
    @(negedge clk);
    chk("t3_beat2_last", 64'(w_last), 64'd1);
    tick();
    wdata_valid_i = 1'b0; w_ready = 1'b0;
    @(negedge clk);
    chk("t3_b_ready", 64'(b_ready), 64'd1);
    chk("t3_no_early_done", 64'(wdone_o), 64'd0);
    tick();
    b_valid = 1'b1;
    @(negedge clk);
    chk("t3_done", 64'(wdone_o), 64'd1);
    tick();
    b_valid = 1'b0;
    tick();
    chk("t3_done_count", 64'(wdone_cnt - cw), 64'd1);
    chk("t3_last_count", 64'(wlast_cnt - cl), 64'd1);

    // Concurrent read (dcache) and write.
    c1 = rv1_cnt; cw = wdone_cnt;
    fork
      begin
        rreq_valid_i = 2'b10; rreq_addr_i[1] = 32'h0000_2000; rreq_len_i[1] = 8'd1;
        tick();
        rreq_valid_i = 2'b00;
        tick();
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'h3333_0001; r_last = 1'b0;
        tick();
        r_valid = 1'b0;
        tick();
        r_valid = 1'b1; r_data = 32'h3333_0002; r_last = 1'b1;
        tick();
        r_valid = 1'b0; r_last = 1'b0;
      end
      begin
        wreq_valid_i = 1'b1; wreq_addr_i = 32'h0000_3000; wreq_len_i = 8'd0;
        tick();
        wreq_valid_i = 1'b0; aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0; wdata_valid_i = 1'b1; w_ready = 1'b1; wdata_i = 32'h4444_0000;
        tick();
        wdata_valid_i = 1'b0; w_ready = 1'b0;
        tick();
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
      end
    join
    tick();
    chk("t4_read_beats", 64'(rv1_cnt - c1), 64'd2);
    chk("t4_write_done", 64'(wdone_cnt - cw), 64'd1);

    // Reset during beat 2 of a 4-beat icache read.
    c0 = rv0_cnt;
    rreq_valid_i = 2'b01; rreq_addr_i[0] = 32'h0000_5000; rreq_len_i[0] = 8'd3;
    tick();
    rreq_valid_i = 2'b00; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'h5555_0001;
    tick();
    r_data = 32'h5555_0002; rst = 1'b1; rreq_valid_i = 2'b10;
    tick();
    r_data = 32'h5555_0003; r_last = 1'b1;
    @(negedge clk);
    chk("t5_ar_valid", 64'(ar_valid), 64'd0);
    chk("t5_r_ready", 64'(r_ready), 64'd0);
    chk("t5_rresp_valid", 64'(rresp_valid_o), 64'd0);
    chk("t5_rresp_last", 64'(rresp_last_o), 64'd0);
    chk("t5_no_grant_in_rst", 64'(rreq_ready_o), 64'd0);
    tick();
    rst = 1'b0; r_valid = 1'b0; r_last = 1'b0;
    @(negedge clk);
    chk("t5_regrant", 64'(rreq_ready_o), 64'b10);
    chk("t5_beats_before_rst", 64'(rv0_cnt - c0), 64'd2);
    tick();
    rreq_valid_i = 2'b00; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0; r_valid = 1'b1; r_last = 1'b1;
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
